// File: rtl/instr_decoder.sv
// Command/data byte decoder sitting between the SPI bridge and the register file.
// Turns {rw, burst, addr} command bytes plus data bytes into single-cycle register read/write strobes.
module instr_decoder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_in,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_out_load,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic              frame_err,
    output logic [1:0]        state_dbg
);

    // Handshake: byte_valid is a 1-cycle push with no back-pressure; a byte is
    // consumed on any edge where cs_active && byte_valid, otherwise it is lost.
    // byte_out_load, read and write are likewise 1-cycle pushes with no ready.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DATA  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    localparam int RW_BIT    = DATA_W - 1;
    localparam int BURST_BIT = DATA_W - 2;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              burst_q;
    logic              ignore_q;
    logic              wr_seen;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            burst_q       <= 1'b0;
            ignore_q      <= 1'b0;
            wr_seen       <= 1'b0;
            byte_out      <= '0;
            byte_out_load <= 1'b0;
            read          <= 1'b0;
            write         <= 1'b0;
            addr          <= '0;
            data_write    <= '0;
            frame_err     <= 1'b0;
        end else begin
            read          <= 1'b0;
            write         <= 1'b0;
            byte_out_load <= 1'b0;
            frame_err     <= 1'b0;

            if (!cs_active) begin
                // Frame ended: a write command with no data byte is a truncated frame.
                if (state == WR_DATA && !wr_seen) begin
                    frame_err <= 1'b1;
                end
                state    <= IDLE;
                ignore_q <= 1'b0;
                wr_seen  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_valid && !ignore_q) begin
                            addr_q  <= byte_in[ADDR_W-1:0];
                            burst_q <= byte_in[BURST_BIT];
                            wr_seen <= 1'b0;
                            if (byte_in[RW_BIT]) begin
                                state <= WR_DATA;
                            end else begin
                                state <= RD_ISSUE;
                                read  <= 1'b1;
                                addr  <= byte_in[ADDR_W-1:0];
                            end
                        end
                    end

                    WR_DATA: begin
                        if (byte_valid) begin
                            write      <= 1'b1;
                            addr       <= addr_q;
                            data_write <= byte_in;
                            wr_seen    <= 1'b1;
                            if (burst_q) begin
                                addr_q <= addr_q + ADDR_W'(1);
                            end else begin
                                state    <= IDLE;
                                ignore_q <= 1'b1;
                            end
                        end
                    end

                    RD_ISSUE: begin
                        // read is high this cycle, so data_read is valid to capture.
                        byte_out      <= data_read;
                        byte_out_load <= 1'b1;
                        state         <= RD_WAIT;
                        if (byte_valid) begin
                            frame_err <= 1'b1;
                        end
                    end

                    RD_WAIT: begin
                        if (byte_valid) begin
                            if (burst_q) begin
                                addr_q <= addr_q + ADDR_W'(1);
                                addr   <= addr_q + ADDR_W'(1);
                                read   <= 1'b1;
                                state  <= RD_ISSUE;
                            end else begin
                                state    <= IDLE;
                                ignore_q <= 1'b1;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: write, read, burst wrap, burst read, aborted frame, overlap error, reset mid-frame.
module tb_instr_decoder;

    logic       clk;
    logic       rst;
    logic       cs_active;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic [7:0] byte_out;
    logic       byte_out_load;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       frame_err;
    logic [1:0] state_dbg;

    int total;
    int bad;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RI   = 2'd2;
    localparam logic [1:0] S_RW   = 2'd3;

    instr_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .cs_active     (cs_active),
        .byte_valid    (byte_valid),
        .byte_in       (byte_in),
        .byte_out      (byte_out),
        .byte_out_load (byte_out_load),
        .read          (read),
        .write         (write),
        .addr          (addr),
        .data_write    (data_write),
        .data_read     (data_read),
        .frame_err     (frame_err),
        .state_dbg     (state_dbg)
    );

    // Register file model: 0x03 -> 0x34, 0x08 -> 0x3F, 0x09 -> 0x3E, 0x0A -> 0x3D, 0x15 -> 0x22.
    assign data_read = {2'b00, addr} ^ 8'h37;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_read"},       32'(read),          32'h0);
        chk({tag, "_write"},      32'(write),         32'h0);
        chk({tag, "_addr"},       32'(addr),          32'h0);
        chk({tag, "_data_write"}, 32'(data_write),    32'h0);
        chk({tag, "_byte_out"},   32'(byte_out),      32'h0);
        chk({tag, "_load"},       32'(byte_out_load), 32'h0);
        chk({tag, "_frame_err"},  32'(frame_err),     32'h0);
        chk({tag, "_state"},      32'(state_dbg),     32'(S_IDLE));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        cs_active  = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        tick(2);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Single write: 0x82, 0x5A
        cs_active = 1'b1;
        tick(2);
        send_byte(8'h82);
        chk("wr_cmd_write", 32'(write), 32'h0);
        chk("wr_cmd_read",  32'(read),  32'h0);
        chk("wr_cmd_state", 32'(state_dbg), 32'(S_WR));
        tick(8);
        send_byte(8'h5A);
        chk("wr_write", 32'(write),      32'h1);
        chk("wr_addr",  32'(addr),       32'h02);
        chk("wr_data",  32'(data_write), 32'h5A);
        chk("wr_read",  32'(read),       32'h0);
        tick();
        chk("wr_write_drop", 32'(write),      32'h0);
        chk("wr_data_hold",  32'(data_write), 32'h5A);
        chk("wr_addr_hold",  32'(addr),       32'h02);
        chk("wr_state_idle", 32'(state_dbg),  32'(S_IDLE));
        tick(8);
        send_byte(8'h03);  // same frame after completion: ignored
        chk("wr_ignore_read",  32'(read),      32'h0);
        chk("wr_ignore_state", 32'(state_dbg), 32'(S_IDLE));
        cs_active = 1'b0;
        tick(2);

        // Single read: 0x03, 0x00
        cs_active = 1'b1;
        tick(2);
        send_byte(8'h03);
        chk("rd_read",  32'(read),          32'h1);
        chk("rd_addr",  32'(addr),          32'h03);
        chk("rd_write", 32'(write),         32'h0);
        chk("rd_load0", 32'(byte_out_load), 32'h0);
        tick();
        chk("rd_read_drop", 32'(read),          32'h0);
        chk("rd_load",      32'(byte_out_load), 32'h1);
        chk("rd_byte_out",  32'(byte_out),      32'h34);
        chk("rd_state",     32'(state_dbg),     32'(S_RW));
        tick();
        chk("rd_load_drop", 32'(byte_out_load), 32'h0);
        tick(6);
        send_byte(8'h00);
        chk("rd_dummy_read",  32'(read),      32'h0);
        chk("rd_dummy_write", 32'(write),     32'h0);
        chk("rd_dummy_state", 32'(state_dbg), 32'(S_IDLE));
        cs_active = 1'b0;
        tick(2);

        // Burst write with address wrap: 0xFE, 0x11, 0x22, 0x33
        cs_active = 1'b1;
        tick(2);
        send_byte(8'hFE);
        tick(8);
        send_byte(8'h11);
        chk("bw0_write", 32'(write), 32'h1);
        chk("bw0_addr",  32'(addr), 32'h3E);
        chk("bw0_data",  32'(data_write), 32'h11);
        tick(8);
        send_byte(8'h22);
        chk("bw1_write", 32'(write), 32'h1);
        chk("bw1_addr",  32'(addr), 32'h3F);
        chk("bw1_data",  32'(data_write), 32'h22);
        tick(8);
        send_byte(8'h33);
        chk("bw2_write", 32'(write), 32'h1);
        chk("bw2_addr",  32'(addr), 32'h00);
        chk("bw2_data",  32'(data_write), 32'h33);
        chk("bw2_state", 32'(state_dbg), 32'(S_WR));
        tick(4);
        cs_active = 1'b0;
        tick();
        chk("bw_end_err",   32'(frame_err), 32'h0);
        chk("bw_end_state", 32'(state_dbg), 32'(S_IDLE));
        tick(2);

        // Burst read: 0x48 + dummy bytes
        cs_active = 1'b1;
        tick(2);
        send_byte(8'h48);
        chk("br0_read", 32'(read), 32'h1);
        chk("br0_addr", 32'(addr), 32'h08);
        tick();
        chk("br0_load", 32'(byte_out_load), 32'h1);
        chk("br0_data", 32'(byte_out), 32'h3F);
        tick(8);
        send_byte(8'hFF);
        chk("br1_read", 32'(read), 32'h1);
        chk("br1_addr", 32'(addr), 32'h09);
        tick();
        chk("br1_load", 32'(byte_out_load), 32'h1);
        chk("br1_data", 32'(byte_out), 32'h3E);
        tick(8);
        send_byte(8'h00);
        chk("br2_read", 32'(read), 32'h1);
        chk("br2_addr", 32'(addr), 32'h0A);
        chk("br2_write", 32'(write), 32'h0);
        tick();
        chk("br2_load", 32'(byte_out_load), 32'h1);
        chk("br2_data", 32'(byte_out), 32'h3D);
        tick(8);
        send_byte(8'h00);
        tick(4);
        cs_active = 1'b0;
        tick(2);

        // Aborted write: 0x85 then cs drop
        cs_active = 1'b1;
        tick(2);
        send_byte(8'h85);
        tick(3);
        cs_active = 1'b0;
        tick();
        chk("abort_err",   32'(frame_err), 32'h1);
        chk("abort_write", 32'(write),     32'h0);
        chk("abort_state", 32'(state_dbg), 32'(S_IDLE));
        tick();
        chk("abort_err_drop", 32'(frame_err), 32'h0);
        tick(2);
        cs_active = 1'b1;
        tick(2);
        send_byte(8'h82);
        tick(8);
        send_byte(8'h77);
        chk("post_abort_write", 32'(write),      32'h1);
        chk("post_abort_addr",  32'(addr),       32'h02);
        chk("post_abort_data",  32'(data_write), 32'h77);
        cs_active = 1'b0;
        tick(2);

        // Byte arriving during RD_ISSUE is a bridge fault
        cs_active = 1'b1;
        tick(2);
        send_byte(8'h03);
        send_byte(8'h99);
        chk("overlap_err",   32'(frame_err),     32'h1);
        chk("overlap_load",  32'(byte_out_load), 32'h1);
        chk("overlap_state", 32'(state_dbg),     32'(S_RW));
        cs_active = 1'b0;
        tick(2);

        // Reset mid-burst: 0xC0, 0xAA, reset, then 0x55 in same frame
        cs_active = 1'b1;
        tick(2);
        send_byte(8'hC0);
        tick(8);
        send_byte(8'hAA);
        chk("mid_write", 32'(write), 32'h1);
        chk("mid_data",  32'(data_write), 32'hAA);
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("mid_reset");
        tick(4);
        send_byte(8'h55);
        chk("mid_rd_read",  32'(read),      32'h1);
        chk("mid_rd_addr",  32'(addr),      32'h15);
        chk("mid_rd_write", 32'(write),     32'h0);
        chk("mid_rd_state", 32'(state_dbg), 32'(S_RI));
        tick();
        chk("mid_rd_load", 32'(byte_out_load), 32'h1);
        chk("mid_rd_data", 32'(byte_out),      32'h22);
        cs_active = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
